oam_shadow_ctrl: RTL and testbench
==================================

// Module: oam_shadow_ctrl
// PURPOSE
//  Double-buffered OAM store sitting directly upstream of the sprite engine.
//  Game logic writes sprite entries into a shadow bank through a valid/ready port.
//  A commit request copies the shadow bank into the active bank at the next vblank start.
//  The sprite engine reads the active bank via oam_addr/oam_data, so it never sees a half-updated frame.
// PARAMETERS
//  OAM_WIDTH  32  entry width; layout [31] rsvd, [30:29] type, [28] enable, [27:18] pos_x,
//                 [17:8] pos_y, [7:6] dir, [5:3] sprite_row, [2:0] sprite_col
//  OAM_DEPTH  8   number of entries; address width AW = $clog2(OAM_DEPTH)
//  SCREEN_W   640 visible width, used only by OAM_CLIP_EN
//  SCREEN_H   480 visible height, used only by OAM_CLIP_EN
// PORTS
//  clk           in   1          system clock (pixel domain)
//  reset         in   1          synchronous, active-high
//  wr_valid      in   1          write request from game logic
//  wr_ready      out  1          shadow bank accepts a write this cycle
//  wr_addr       in   AW         shadow entry index
//  wr_data       in   OAM_WIDTH  entry value
//  commit        in   1          1-cycle pulse: publish shadow bank at next vblank
//  vblank_start  in   1          1-cycle pulse at first non-visible line
//  oam_addr      in   AW         active-bank read index from the sprite engine
//  oam_data      out  OAM_WIDTH  active-bank entry, registered
//  busy          out  1          commit pending or copy in progress
//  committed     out  1          1-cycle pulse when the copy completes
//  wr_clipped    out  1          1-cycle pulse; only driven when OAM_CLIP_EN is defined, else tied 0
// BEHAVIOUR
//  Reset values: both banks all-zero (every entry disabled), oam_data=0, busy=0,
//   committed=0, wr_clipped=0, FSM=IDLE, copy index=0, wr_ready=1 on the first cycle after reset.
//  Write:
//   - Transfer occurs when wr_valid && wr_ready.
//   - Shadow[wr_addr] is updated on that edge.
//   - wr_ready = (state != COPY).
//  Read:
//   - oam_data <= active[oam_addr] every cycle, giving 1-cycle latency.
//   - Reads are never stalled.
//  FSM states:
//   - IDLE:    on commit -> PENDING. If vblank_start arrives in the same cycle -> COPY directly.
//   - PENDING: on vblank_start -> COPY, with index=0. A further commit is absorbed (no effect).
//   - COPY:    each cycle copies active[idx] <= shadow[idx], then idx++.
//              After idx==OAM_DEPTH-1 -> IDLE and pulse committed.
//              Copy duration is exactly OAM_DEPTH cycles.
//              A commit during COPY sets a latched flag; on exit the FSM goes to PENDING instead of IDLE.
//   - busy = (state != IDLE).
//  Simultaneous events:
//   - A write accepted in the same cycle as commit is included in that commit.
//   - vblank_start while in IDLE without commit is ignored.
//   - vblank_start during COPY is ignored.
//  Read during COPY returns new data for entries already copied and old data otherwise.
//   This is acceptable because copy occurs in vblank.
//  Reset mid-COPY aborts the copy and clears both banks; the pending flag is cleared.
// CONFIGURATION
//  OAM_CLIP_EN defined:
//   - Any accepted write with pos_x >= SCREEN_W or pos_y >= SCREEN_H is stored with enable bit [28] forced to 0.
//   - wr_clipped pulses in the cycle after the write. All other fields are stored unchanged.
//  OAM_CLIP_EN undefined:
//   - Data is stored verbatim.
//   - wr_clipped is constant 0.
// STRUCTURE
//  oam_pkg:
//   - Field bit-range localparams (TYPE_HI/LO, EN_BIT, X_HI/LO, Y_HI/LO, DIR_HI/LO, ROW_HI/LO, COL_HI/LO).
//   - obj_type_t enum: PLAYER=2'b00, OPPONENT=2'b01, BULLET=2'b10, RSVD=2'b11.
//   - oam_state_t enum: IDLE/PENDING/COPY.
//  Sub-module oam_bank_ram:
//   - One instance per bank: one write port, one registered read port, synchronous clear.
//   - The active bank also needs a combinational read port for the copy path.
//   - Alternatively, the copy reads the shadow bank via its own read port with a 1-cycle pipelined index.
// TESTING
//  1. Reset, then read addr 0..7 -> oam_data=0 on each, 1 cycle after the address is presented.
//  2. Write shadow[3]=32'h1234_5678 with no commit; pulse vblank_start -> active[3] reads 0; busy=0.
//  3. Write shadow[3], pulse commit, wait 20 cycles, pulse vblank_start:
//     - busy=1 from the commit;
//     - wr_ready=0 for exactly 8 cycles;
//     - committed pulses on the 8th copy cycle;
//     - active[3]=32'h1234_5678.
//  4. Pulse commit during COPY -> FSM returns to PENDING, busy stays 1; the next vblank_start copies again.
//  5. Assert reset on copy cycle 4 -> all reads return 0 and busy=0 on the next cycle.
//  6. With OAM_CLIP_EN defined, write pos_x=700 with enable=1 -> wr_clipped=1; after commit, entry bit[28]=0.
//     With OAM_CLIP_EN undefined, the same write -> bit[28]=1 and wr_clipped=0.

Source files
------------

// File: rtl/oam_pkg.sv
// Shared field layout, object types and controller states for the
// double-buffered OAM store.
package oam_pkg;

    localparam int TYPE_HI = 30;
    localparam int TYPE_LO = 29;
    localparam int EN_BIT  = 28;
    localparam int X_HI    = 27;
    localparam int X_LO    = 18;
    localparam int Y_HI    = 17;
    localparam int Y_LO    = 8;
    localparam int DIR_HI  = 7;
    localparam int DIR_LO  = 6;
    localparam int ROW_HI  = 5;
    localparam int ROW_LO  = 3;
    localparam int COL_HI  = 2;
    localparam int COL_LO  = 0;

    typedef enum logic [1:0] {
        PLAYER   = 2'b00,
        OPPONENT = 2'b01,
        BULLET   = 2'b10,
        RSVD     = 2'b11
    } obj_type_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COPY    = 2'd2
    } oam_state_t;

    // True when the entry's position lies outside a w x h screen.
    function automatic logic off_screen(
        input logic [31:0] d,
        input int          w,
        input int          h
    );
        off_screen = (int'(d[X_HI:X_LO]) >= w)
                  || (int'(d[Y_HI:Y_LO]) >= h);
    endfunction

endpackage

// File: rtl/oam_bank_ram.sv
// One OAM bank: single write port, registered write-first read port,
// synchronous clear of the whole array.
module oam_bank_ram #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            // Same-cycle write is forwarded so the copy path never
            // misses an entry written on the cycle the copy is armed.
            if (we && (waddr == raddr)) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/oam_shadow_ctrl.sv
// Double-buffered OAM: shadow bank written by game logic, copied into the
// active bank at vblank. Optional off-screen clipping via OAM_CLIP_EN.
module oam_shadow_ctrl
    import oam_pkg::*;
#(
    parameter int OAM_WIDTH = 32,
    parameter int OAM_DEPTH = 8,
`ifdef OAM_CLIP_EN
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
`endif
    localparam int AW = $clog2(OAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [AW-1:0]        wr_addr,
    input  logic [OAM_WIDTH-1:0] wr_data,
    input  logic                 commit,
    input  logic                 vblank_start,
    input  logic [AW-1:0]        oam_addr,
    output logic [OAM_WIDTH-1:0] oam_data,
    output logic                 busy,
    output logic                 committed,
    output logic                 wr_clipped
);

    localparam logic [AW-1:0] LAST = AW'(OAM_DEPTH - 1);

    oam_state_t     state;
    oam_state_t     state_nxt;
    logic [AW-1:0]  idx;
    logic [AW-1:0]  idx_nxt;
    logic           again;
    logic           again_nxt;
    logic           wr_fire;
    logic           last;
    logic           copying;
    logic [AW-1:0]  sh_raddr;
    logic [OAM_WIDTH-1:0] sh_q;
    logic [OAM_WIDTH-1:0] wr_data_st;

    assign copying  = (state == COPY);
    assign last     = (idx == LAST);
    assign wr_ready = !copying;
    assign wr_fire  = wr_valid && wr_ready;
    assign busy     = (state != IDLE);
    assign committed = copying && last;

    // Shadow read runs one entry ahead so its registered output
    // holds shadow[idx] during copy cycle idx.
    assign sh_raddr = copying ? idx + AW'(1) : '0;

`ifdef OAM_CLIP_EN
    logic clip_hit;

    assign clip_hit = off_screen(wr_data, SCREEN_W, SCREEN_H);

    always_comb begin
        wr_data_st = wr_data;
        if (clip_hit) begin
            wr_data_st[EN_BIT] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_clipped <= 1'b0;
        end else begin
            wr_clipped <= wr_fire && clip_hit;
        end
    end
`else
    assign wr_data_st = wr_data;
    assign wr_clipped = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            again <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            again <= again_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        again_nxt = again;
        unique case (state)
            IDLE: begin
                if (commit) begin
                    idx_nxt   = '0;
                    state_nxt = vblank_start ? COPY : PENDING;
                end
            end
            PENDING: begin
                if (vblank_start) begin
                    idx_nxt   = '0;
                    state_nxt = COPY;
                end
            end
            COPY: begin
                if (last) begin
                    idx_nxt   = '0;
                    again_nxt = 1'b0;
                    state_nxt = (again || commit) ? PENDING : IDLE;
                end else begin
                    idx_nxt   = idx + AW'(1);
                    again_nxt = again || commit;
                end
            end
            default: begin
                idx_nxt   = '0;
                again_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    oam_bank_ram #(
        .W     (OAM_WIDTH),
        .DEPTH (OAM_DEPTH),
        .AW    (AW)
    ) u_shadow (
        .clk   (clk),
        .clear (reset),
        .we    (wr_fire),
        .waddr (wr_addr),
        .wdata (wr_data_st),
        .raddr (sh_raddr),
        .rdata (sh_q)
    );

    oam_bank_ram #(
        .W     (OAM_WIDTH),
        .DEPTH (OAM_DEPTH),
        .AW    (AW)
    ) u_active (
        .clk   (clk),
        .clear (reset),
        .we    (copying),
        .waddr (idx),
        .wdata (sh_q),
        .raddr (oam_addr),
        .rdata (oam_data)
    );

endmodule

// File: tb/tb_oam_shadow_ctrl.sv
// Scoreboard bench for oam_shadow_ctrl: directed scenarios followed by
// random traffic, all checked against a transaction-level model.
module tb_oam_shadow_ctrl;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        commit;
    logic        vblank_start;
    logic [2:0]  oam_addr;
    logic [31:0] oam_data;
    logic        busy;
    logic        committed;
    logic        wr_clipped;

    oam_shadow_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .commit       (commit),
        .vblank_start (vblank_start),
        .oam_addr     (oam_addr),
        .oam_data     (oam_data),
        .busy         (busy),
        .committed    (committed),
        .wr_clipped   (wr_clipped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          chk_data;
        logic [31:0] data;
        bit          busy;
        bit          ready;
        bit          cmt;
        bit          clip;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: two bank images plus a publish request tracker.
    logic [31:0] sh_m [8];
    logic [31:0] ac_m [8];
    bit          m_pend;
    bit          m_copy;
    bit          m_again;
    int          m_pos;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, req, $time);
        end
    endtask

    task automatic step(input bit rst, input bit wv, input int wa,
                        input logic [31:0] wd, input bit cm,
                        input bit vb, input int ra);
        exp_t        e;
        logic [31:0] d;
        bit          acc;
        @(negedge clk);
        reset        = rst;
        wr_valid     = wv;
        wr_addr      = 3'(wa);
        wr_data      = wd;
        commit       = cm;
        vblank_start = vb;
        oam_addr     = 3'(ra);
        e.clip = 1'b0;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                sh_m[i] = '0;
                ac_m[i] = '0;
            end
            m_pend = 0; m_copy = 0; m_again = 0; m_pos = 0;
            e.chk_data = 1;
            e.data     = '0;
        end else begin
            e.chk_data = !m_copy;
            e.data     = ac_m[ra];
            acc = wv && !m_copy;
            if (acc) begin
                d = wd;
`ifdef OAM_CLIP_EN
                if (int'(wd[27:18]) >= 640 || int'(wd[17:8]) >= 480) begin
                    d[28]  = 1'b0;
                    e.clip = 1'b1;
                end
`endif
                sh_m[wa] = d;
            end
            if (m_copy) begin
                ac_m[m_pos] = sh_m[m_pos];
                if (m_pos == 7) begin
                    m_copy  = 0;
                    m_pend  = m_again || cm;
                    m_again = 0;
                end else begin
                    m_pos++;
                    m_again = m_again || cm;
                end
            end else if (m_pend) begin
                if (vb) begin
                    m_copy = 1; m_pos = 0; m_pend = 0;
                end
            end else if (cm) begin
                if (vb) begin
                    m_copy = 1; m_pos = 0;
                end else begin
                    m_pend = 1;
                end
            end
        end
        e.busy  = m_pend || m_copy;
        e.ready = !m_copy;
        e.cmt   = m_copy && (m_pos == 7);
        q.push_back(e);
    endtask

    task automatic idle(input int n, input int ra);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, '0, 0, 0, ra);
        end
    endtask

    exp_t me;
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            me = q.pop_front();
            if (me.chk_data) chk("oam_data", oam_data, me.data);
            chk("busy", 32'(busy), 32'(me.busy));
            chk("wr_ready", 32'(wr_ready), 32'(me.ready));
            chk("committed", 32'(committed), 32'(me.cmt));
            chk("wr_clipped", 32'(wr_clipped), 32'(me.clip));
        end
    end

    logic [31:0] clip_val;
    logic [31:0] rd;

    initial begin
        reset = 1; wr_valid = 0; wr_addr = 0; wr_data = 0;
        commit = 0; vblank_start = 0; oam_addr = 0;
        step(1, 0, 0, '0, 0, 0, 0);
        step(1, 0, 0, '0, 0, 0, 0);
        for (int i = 0; i < 8; i++) idle(1, i);

        step(0, 1, 3, 32'h1234_5678, 0, 0, 3);
        step(0, 0, 0, '0, 0, 1, 3);
        idle(3, 3);

        step(0, 1, 3, 32'h1234_5678, 1, 0, 3);
        idle(20, 3);
        step(0, 0, 0, '0, 0, 1, 3);
        idle(12, 3);

        step(0, 1, 6, 32'h0bad_cafe, 1, 0, 6);
        step(0, 0, 0, '0, 0, 1, 6);
        idle(3, 6);
        step(0, 0, 0, '0, 1, 0, 6);
        idle(10, 6);
        step(0, 1, 6, 32'h0000_1111, 0, 1, 6);
        idle(12, 6);

        for (int i = 0; i < 8; i++) begin
            step(0, 1, i, 32'h1000_0000 + 32'(i), 0, 0, 0);
        end
        step(0, 0, 0, '0, 1, 1, 0);
        idle(3, 0);
        step(1, 0, 0, '0, 0, 0, 0);
        for (int i = 0; i < 8; i++) idle(1, i);

        clip_val = (32'd700 << 18) | (32'd1 << 28) | (32'd100 << 8);
        step(0, 1, 5, clip_val, 1, 1, 5);
        idle(12, 5);

        for (int i = 0; i < 3000; i++) begin
            rd = $urandom;
            if ($urandom_range(0, 1) == 0) rd[27] = 1'b0;
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 2) != 0,
                 int'($urandom_range(0, 7)), rd,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 14) == 0,
                 int'($urandom_range(0, 7)));
        end
        idle(3, 0);
        @(posedge clk);
        #3;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
